// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags (busy + ROB id).
// Combinational reads bypass same-cycle commits. Branch checkpoints snapshot the rename table.
module rename_regfile #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int ROB_ID_W   = 4,
  parameter int NUM_READ   = 2,
  parameter int NUM_COMMIT = 1,
  parameter int NUM_CKPT   = 4,
  localparam int REG_W     = $clog2(NUM_REGS),
  localparam int CKPT_W    = $clog2(NUM_CKPT)
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           rename_en,
  input  logic [REG_W-1:0]               rename_reg,
  input  logic [ROB_ID_W-1:0]            rename_tag,
  input  logic [NUM_COMMIT-1:0]          commit_en,
  input  logic [NUM_COMMIT*REG_W-1:0]    commit_reg,
  input  logic [NUM_COMMIT*ROB_ID_W-1:0] commit_tag,
  input  logic [NUM_COMMIT*XLEN-1:0]     commit_data,
  input  logic [NUM_READ*REG_W-1:0]      rd_reg,
  output logic [NUM_READ*XLEN-1:0]       rd_data,
  output logic [NUM_READ-1:0]            rd_busy,
  output logic [NUM_READ*ROB_ID_W-1:0]   rd_tag,
  input  logic                           ckpt_save_en,
  input  logic [CKPT_W-1:0]              ckpt_save_id,
  input  logic                           ckpt_restore_en,
  input  logic [CKPT_W-1:0]              ckpt_restore_id,
  input  logic                           flush_in
);

  logic [XLEN-1:0]     data_q      [NUM_REGS];
  logic [XLEN-1:0]     data_d      [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [ROB_ID_W-1:0] tag_q       [NUM_REGS];
  logic [ROB_ID_W-1:0] tag_d       [NUM_REGS];
  logic [NUM_REGS-1:0] ckpt_busy_q [NUM_CKPT];
  logic [NUM_REGS-1:0] ckpt_busy_d [NUM_CKPT];
  logic [ROB_ID_W-1:0] ckpt_tag_q  [NUM_CKPT][NUM_REGS];
  logic [ROB_ID_W-1:0] ckpt_tag_d  [NUM_CKPT][NUM_REGS];

  logic [REG_W-1:0]      c_reg  [NUM_COMMIT];
  logic [ROB_ID_W-1:0]   c_tag  [NUM_COMMIT];
  logic [XLEN-1:0]       c_data [NUM_COMMIT];
  logic [NUM_COMMIT-1:0] c_valid;
  logic [NUM_COMMIT-1:0] c_live_hit;
  logic [NUM_REGS-1:0]   live_clr;
  logic [NUM_REGS-1:0]   ckpt_clr [NUM_CKPT];

  genvar gi;

  // A commit only clears busy when it is still the youngest producer (tag matches pre-edge tag).
  for (gi = 0; gi < NUM_COMMIT; gi++) begin : g_commit
    assign c_reg[gi]      = commit_reg[gi*REG_W +: REG_W];
    assign c_tag[gi]      = commit_tag[gi*ROB_ID_W +: ROB_ID_W];
    assign c_data[gi]     = commit_data[gi*XLEN +: XLEN];
    assign c_valid[gi]    = commit_en[gi] && (c_reg[gi] != '0);
    assign c_live_hit[gi] = c_valid[gi] && busy_q[c_reg[gi]] && (tag_q[c_reg[gi]] == c_tag[gi]);
  end

  always_comb begin
    live_clr = '0;
    for (int p = 0; p < NUM_COMMIT; p++) begin
      if (c_live_hit[p]) live_clr[c_reg[p]] = 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CKPT; c++) begin
      ckpt_clr[c] = '0;
      for (int p = 0; p < NUM_COMMIT; p++) begin
        if (c_valid[p] && ckpt_busy_q[c][c_reg[p]] && (ckpt_tag_q[c][c_reg[p]] == c_tag[p]))
          ckpt_clr[c][c_reg[p]] = 1'b1;
      end
    end
  end

  // Later ports overwrite earlier ones, so the highest-index port wins a shared register.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) data_d[r] = data_q[r];
    for (int p = 0; p < NUM_COMMIT; p++) begin
      if (c_valid[p]) data_d[c_reg[p]] = c_data[p];
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NUM_REGS; r++) tag_d[r] = tag_q[r];
    if (flush_in) begin
      busy_d = '0;
    end else if (ckpt_restore_en) begin
      busy_d = ckpt_busy_q[ckpt_restore_id] & ~ckpt_clr[ckpt_restore_id];
      for (int r = 0; r < NUM_REGS; r++) tag_d[r] = ckpt_tag_q[ckpt_restore_id][r];
    end else begin
      busy_d = busy_q & ~live_clr;
      if (rename_en && (rename_reg != '0)) begin
        busy_d[rename_reg] = 1'b1;
        tag_d[rename_reg]  = rename_tag;
      end
    end
    busy_d[0] = 1'b0;
  end

  // The saved slot takes the fully updated live table, including any restore this cycle.
  always_comb begin
    for (int c = 0; c < NUM_CKPT; c++) begin
      ckpt_busy_d[c] = flush_in ? '0 : (ckpt_busy_q[c] & ~ckpt_clr[c]);
      for (int r = 0; r < NUM_REGS; r++) ckpt_tag_d[c][r] = ckpt_tag_q[c][r];
    end
    if (!flush_in && ckpt_save_en) begin
      ckpt_busy_d[ckpt_save_id] = busy_d;
      for (int r = 0; r < NUM_REGS; r++) ckpt_tag_d[ckpt_save_id][r] = tag_d[r];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      for (int c = 0; c < NUM_CKPT; c++) begin
        ckpt_busy_q[c] <= '0;
        for (int r = 0; r < NUM_REGS; r++) ckpt_tag_q[c][r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= data_d[r];
        tag_q[r]  <= tag_d[r];
      end
      for (int c = 0; c < NUM_CKPT; c++) begin
        ckpt_busy_q[c] <= ckpt_busy_d[c];
        for (int r = 0; r < NUM_REGS; r++) ckpt_tag_q[c][r] <= ckpt_tag_d[c][r];
      end
    end
  end

  // Reads see pre-edge state plus commit bypass; a same-cycle rename is deliberately invisible.
  for (gi = 0; gi < NUM_READ; gi++) begin : g_read
    logic [REG_W-1:0] addr;
    logic             byp_hit;
    logic [XLEN-1:0]  byp_data;

    assign addr = rd_reg[gi*REG_W +: REG_W];

    always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int p = 0; p < NUM_COMMIT; p++) begin
        if (c_live_hit[p] && (c_reg[p] == addr)) begin
          byp_hit  = 1'b1;
          byp_data = c_data[p];
        end
      end
    end

    assign rd_data[gi*XLEN +: XLEN]         = (addr == '0) ? '0 : (byp_hit ? byp_data : data_q[addr]);
    assign rd_busy[gi]                      = (addr != '0) && !byp_hit && busy_q[addr];
    assign rd_tag[gi*ROB_ID_W +: ROB_ID_W]  = (addr == '0) ? '0 : tag_q[addr];
  end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: each task queues expected read results
// as it drives stimulus, then drains the queue against the read ports.
module tb_rename_regfile;
  localparam int XLEN = 32, NR = 32, RW = 4, NRD = 2, NCM = 2, NCK = 4;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rename_en;
  logic [4:0]        rename_reg;
  logic [RW-1:0]     rename_tag;
  logic [NCM-1:0]    commit_en;
  logic [NCM*5-1:0]  commit_reg;
  logic [NCM*RW-1:0] commit_tag;
  logic [NCM*32-1:0] commit_data;
  logic [NRD*5-1:0]  rd_reg;
  logic [NRD*32-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NRD*RW-1:0] rd_tag;
  logic              ckpt_save_en;
  logic [1:0]        ckpt_save_id;
  logic              ckpt_restore_en;
  logic [1:0]        ckpt_restore_id;
  logic              flush_in;

  rename_regfile #(.XLEN(XLEN), .NUM_REGS(NR), .ROB_ID_W(RW), .NUM_READ(NRD),
                   .NUM_COMMIT(NCM), .NUM_CKPT(NCK)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .rename_en(rename_en), .rename_reg(rename_reg), .rename_tag(rename_tag),
    .commit_en(commit_en), .commit_reg(commit_reg), .commit_tag(commit_tag), .commit_data(commit_data),
    .rd_reg(rd_reg), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .ckpt_save_en(ckpt_save_en), .ckpt_save_id(ckpt_save_id),
    .ckpt_restore_en(ckpt_restore_en), .ckpt_restore_id(ckpt_restore_id),
    .flush_in(flush_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic idle();
    rename_en = 0; rename_reg = '0; rename_tag = '0;
    commit_en = '0; commit_reg = '0; commit_tag = '0; commit_data = '0;
    ckpt_save_en = 0; ckpt_save_id = '0; ckpt_restore_en = 0; ckpt_restore_id = '0;
    flush_in = 0; rd_reg = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 0;
    tick(); tick();
    rst_in = 1;
  endtask

  task automatic set_rename(input logic [4:0] r, input logic [3:0] t);
    rename_en = 1; rename_reg = r; rename_tag = t;
  endtask

  task automatic set_commit(input int p, input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
    commit_en[p] = 1'b1;
    commit_reg[p*5 +: 5] = r;
    commit_tag[p*4 +: 4] = t;
    commit_data[p*32 +: 32] = d;
  endtask

  task automatic expect_rd(input string name, input int port, input logic [4:0] r,
                           input logic [31:0] d, input logic b, input logic [3:0] t);
    rd_reg[port*5 +: 5] = r;
    sb.push_back('{name, port, d, b, t});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    exp_t e;
    idle();
    rst_in = 0;
    set_rename(5'd1, 4'd5);
    set_commit(0, 5'd2, 4'd0, 32'h1234_5678);
    tick(); tick();
    rst_in = 1;
    idle();
    for (int r = 0; r < 16; r++) begin
      expect_rd("reset_lo", 0, 5'(r), 32'h0, 1'b0, 4'h0);
      expect_rd("reset_hi", 1, 5'(r + 16), 32'h0, 1'b0, 4'h0);
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front(); vectors++;
        if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
          miscompares++;
          $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
        end
      end
    end
    $display("[%0t] test_reset: all registers read back after reset", $time);
    set_rename(5'd0, 4'd5);
    tick(); idle();
    expect_rd("x0_rename", 0, 5'd0, 32'h0, 1'b0, 4'h0);
    expect_rd("x1_after_reset", 1, 5'd1, 32'h0, 1'b0, 4'h0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    $display("[%0t] test_reset: rename of x0 ignored", $time);
  endtask

  task automatic test_bypass();
    exp_t e;
    do_reset();
    set_rename(5'd5, 4'd3); tick(); idle();
    expect_rd("renamed_x5", 0, 5'd5, 32'h0, 1'b1, 4'd3);
    expect_rd("untouched_x6", 1, 5'd6, 32'h0, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    set_commit(0, 5'd5, 4'd3, 32'hDEAD_BEEF);
    expect_rd("bypass_p0", 0, 5'd5, 32'hDEAD_BEEF, 1'b0, 4'd0);
    expect_rd("bypass_p1", 1, 5'd5, 32'hDEAD_BEEF, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    tick(); idle();
    expect_rd("after_commit", 0, 5'd5, 32'hDEAD_BEEF, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    $display("[%0t] test_bypass: rename/commit x5 tag 3", $time);
  endtask

  task automatic test_stale_commit();
    exp_t e;
    do_reset();
    set_rename(5'd5, 4'd3); tick(); idle();
    set_rename(5'd5, 4'd7); tick(); idle();
    set_commit(0, 5'd5, 4'd3, 32'h11);
    expect_rd("stale_no_bypass", 0, 5'd5, 32'h0, 1'b1, 4'd7);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    tick(); idle();
    expect_rd("stale_data_only", 0, 5'd5, 32'h11, 1'b1, 4'd7);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    set_commit(0, 5'd5, 4'd7, 32'h22); tick(); idle();
    expect_rd("young_commit", 0, 5'd5, 32'h22, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    $display("[%0t] test_stale_commit: x5 tags 3 then 7", $time);
  endtask

  task automatic test_rename_beats_commit();
    exp_t e;
    do_reset();
    set_rename(5'd6, 4'd1); tick(); idle();
    set_rename(5'd6, 4'd2);
    set_commit(0, 5'd6, 4'd1, 32'h66);
    expect_rd("read_ignores_rename", 0, 5'd6, 32'h66, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    tick(); idle();
    expect_rd("rename_wins", 0, 5'd6, 32'h66, 1'b1, 4'd2);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    $display("[%0t] test_rename_beats_commit: x6", $time);
  endtask

  task automatic test_commit_ports();
    exp_t e;
    do_reset();
    set_rename(5'd7, 4'd9); tick(); idle();
    set_commit(0, 5'd7, 4'd9, 32'hAAAA_0000);
    set_commit(1, 5'd7, 4'd9, 32'hBBBB_1111);
    expect_rd("dual_bypass", 0, 5'd7, 32'hBBBB_1111, 1'b0, 4'd0);
    expect_rd("x0_zero", 1, 5'd0, 32'h0, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    tick(); idle();
    expect_rd("high_port_wins", 1, 5'd7, 32'hBBBB_1111, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    $display("[%0t] test_commit_ports: two ports to x7", $time);
  endtask

  task automatic test_checkpoint();
    exp_t e;
    do_reset();
    set_rename(5'd8, 4'd1); tick(); idle();
    ckpt_save_en = 1; ckpt_save_id = 2'd2; tick(); idle();
    set_rename(5'd8, 4'd4); tick(); idle();
    set_commit(0, 5'd8, 4'd1, 32'h88); tick(); idle();
    ckpt_restore_en = 1; ckpt_restore_id = 2'd2; tick(); idle();
    expect_rd("snapshot_cleared", 0, 5'd8, 32'h88, 1'b0, 4'd0);
    expect_rd("x10_idle", 1, 5'd10, 32'h0, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    // save captures the same-cycle rename
    set_rename(5'd10, 4'd5); ckpt_save_en = 1; ckpt_save_id = 2'd1; tick(); idle();
    set_rename(5'd10, 4'd6); tick(); idle();
    ckpt_restore_en = 1; ckpt_restore_id = 2'd1; set_rename(5'd11, 4'd3); tick(); idle();
    expect_rd("restored_tag", 0, 5'd10, 32'h0, 1'b1, 4'd5);
    expect_rd("rename_discarded", 1, 5'd11, 32'h0, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    set_rename(5'd10, 4'd12); tick(); idle();
    ckpt_restore_en = 1; ckpt_restore_id = 2'd1; ckpt_save_en = 1; ckpt_save_id = 2'd3; tick(); idle();
    set_rename(5'd10, 4'd13); tick(); idle();
    ckpt_restore_en = 1; ckpt_restore_id = 2'd3; tick(); idle();
    expect_rd("save_after_restore", 0, 5'd10, 32'h0, 1'b1, 4'd5);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    ckpt_restore_en = 1; ckpt_restore_id = 2'd1; set_commit(0, 5'd10, 4'd5, 32'h1010);
    expect_rd("restore_commit_bypass", 0, 5'd10, 32'h1010, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    tick(); idle();
    expect_rd("restore_with_clear", 0, 5'd10, 32'h1010, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    $display("[%0t] test_checkpoint: save/restore slots 1..3", $time);
  endtask

  task automatic test_flush();
    exp_t e;
    do_reset();
    set_rename(5'd3, 4'd2); tick(); idle();
    set_rename(5'd9, 4'd4); tick(); idle();
    ckpt_save_en = 1; ckpt_save_id = 2'd0; tick(); idle();
    set_rename(5'd3, 4'd6); ckpt_save_en = 1; ckpt_save_id = 2'd3; tick(); idle();
    flush_in = 1; set_commit(0, 5'd9, 4'd4, 32'h99); set_rename(5'd12, 4'd1);
    expect_rd("flush_bypass_x9", 0, 5'd9, 32'h99, 1'b0, 4'd0);
    expect_rd("pre_flush_x3", 1, 5'd3, 32'h0, 1'b1, 4'd6);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    tick(); idle();
    expect_rd("flushed_x9", 0, 5'd9, 32'h99, 1'b0, 4'd0);
    expect_rd("flushed_x12", 1, 5'd12, 32'h0, 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    for (int s = 0; s < NCK; s++) begin
      ckpt_restore_en = 1; ckpt_restore_id = 2'(s); tick(); idle();
      expect_rd("restore_after_flush_x3", 0, 5'd3, 32'h0, 1'b0, 4'd0);
      expect_rd("restore_after_flush_x9", 1, 5'd9, 32'h99, 1'b0, 4'd0);
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front(); vectors++;
        if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
          miscompares++;
          $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
        end
      end
      $display("[%0t] test_flush: restore slot %0d after flush", $time, s);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] d [8];
    do_reset();
    for (int k = 0; k < 8; k++) begin
      d[k] = $urandom;
      idle();
      set_rename(5'(16 + k), 4'(k));
      if (k > 0) begin
        set_commit(0, 5'(15 + k), 4'(k - 1), d[k-1]);
        expect_rd("b2b_bypass", 0, 5'(15 + k), d[k-1], 1'b0, 4'd0);
      end else begin
        expect_rd("b2b_idle", 0, 5'd15, 32'h0, 1'b0, 4'd0);
      end
      expect_rd("b2b_rename_hidden", 1, 5'(16 + k), 32'h0, 1'b0, 4'd0);
      #1;
      while (sb.size() != 0) begin
        e = sb.pop_front(); vectors++;
        if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
          miscompares++;
          $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
        end
      end
      $display("[%0t] test_back_to_back: cycle %0d", $time, k);
      tick();
    end
    idle();
    expect_rd("b2b_last_busy", 0, 5'd23, 32'h0, 1'b1, 4'd7);
    expect_rd("b2b_first_data", 1, 5'd16, d[0], 1'b0, 4'd0);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (rd_data[e.port*32 +: 32] !== e.data || rd_busy[e.port] !== e.busy || (e.busy && rd_tag[e.port*4 +: 4] !== e.tag)) begin
        miscompares++;
        $display("FAIL %s port%0d: got data=%h busy=%b tag=%h, expected data=%h busy=%b tag=%h", e.name, e.port, rd_data[e.port*32 +: 32], rd_busy[e.port], rd_tag[e.port*4 +: 4], e.data, e.busy, e.tag);
      end
    end
    $display("[%0t] test_back_to_back: final state", $time);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_in = 0;
    test_reset();
    test_bypass();
    test_stale_commit();
    test_rename_beats_commit();
    test_commit_ports();
    test_checkpoint();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with a per-register rename tag (busy bit plus ROB id).
- Sits between the decoder (rename and operand read) and the ROB (commit writeback).
- Adds explicit busy bits, tag-matched busy clearing, N read ports with same-cycle commit bypass, M commit ports, and branch checkpoints of the rename table with restore on mispredict.
- Register 0 is hardwired to zero and is never busy.

Parameters:
XLEN, 32, data width
NUM_REGS, 32, architectural register count (power of 2)
ROB_ID_W, 4, ROB tag width
NUM_READ, 2, decoder read ports
NUM_COMMIT, 1, ROB commit ports
NUM_CKPT, 4, checkpoint slots (power of 2)

Ports:
clk_in  in  1  clock, all state updates on rising edge
rst_in  in  1  reset; synchronous, active-low (0 = reset)
rename_en  in  1  decoder allocates a new producer
rename_reg  in  log2(NUM_REGS)  destination register
rename_tag  in  ROB_ID_W  ROB id of the producer
commit_en  in  NUM_COMMIT  per-port commit valid
commit_reg  in  NUM_COMMIT*log2(NUM_REGS)  packed destination registers
commit_tag  in  NUM_COMMIT*ROB_ID_W  packed ROB ids
commit_data  in  NUM_COMMIT*XLEN  packed results
rd_reg  in  NUM_READ*log2(NUM_REGS)  packed read addresses
rd_data  out  NUM_READ*XLEN  value (bypassed)
rd_busy  out  NUM_READ  1 = value still pending
rd_tag  out  NUM_READ*ROB_ID_W  pending producer tag; valid only when busy
ckpt_save_en  in  1  snapshot the rename table
ckpt_save_id  in  log2(NUM_CKPT)  snapshot slot
ckpt_restore_en  in  1  restore the rename table from a slot
ckpt_restore_id  in  log2(NUM_CKPT)  slot to restore
flush_in  in  1  full pipeline flush

Behaviour:
- Reset (rst_in=0 at a clock edge): all data, busy bits and tags cleared to 0; all checkpoint busy bits cleared. Outputs follow combinationally, so rd_data=0 and rd_busy=0 after reset. Reset has priority over every other input.
- Priority among the remaining events: flush_in > ckpt_restore_en > normal update.
- Flush: all live and checkpoint busy bits cleared. Data registers are still written by the same-cycle commits.
- Commit, per port p, when commit_en[p]=1 and the register is not 0:
  - data[reg] <= commit_data[p], unconditionally.
  - The live busy bit clears only if busy[reg] && tag[reg] == commit_tag[p].
  - If ports share a register, the highest-index port wins the data write.
- Rename (rename_en=1, register not 0): busy <= 1 and tag <= rename_tag. A rename beats a commit to the same register in the same cycle.
- Checkpoints:
  - Save: slot <= the rename table as it stands after this cycle's rename and commit effects.
  - Commit tag-match clearing also applies to every checkpoint slot, so a snapshot never holds a stale busy bit.
  - Restore: the live busy/tag table <= the slot contents, with this cycle's commit clears applied. A rename in the same cycle is discarded.
  - Save and restore in the same cycle: the restore applies first, then the saved slot receives the restored table.
  - Register data is never checkpointed.
- Reads (combinational):
  - Register 0 returns data 0 and busy 0.
  - If a same-cycle commit matches the live tag of a busy register, the read returns commit_data with busy 0 (bypass).
  - Otherwise the read returns the stored data, busy and tag.
  - Reads ignore a same-cycle rename: the decoder reads sources before renaming its destination.
- Tag-match is compared against the pre-edge tag. A commit whose tag mismatches (a younger producer already renamed the register) updates data only.

Test Plan:
1. Reset with rst_in=0 for 2 cycles, then rst_in=1 -> every rd_data=0 and rd_busy=0; rename_reg=0 -> rd_busy of x0 stays 0.
2. Rename x5 with tag 3, then commit x5 with tag 3 and data 0xDEADBEEF -> rd_busy=0 and rd_data=0xDEADBEEF the same cycle (bypass) and thereafter.
3. Rename x5 with tag 3, rename x5 with tag 7, commit x5 with tag 3 and data 0x11 -> data=0x11, busy stays 1, tag stays 7.
4. Same-cycle rename of x6 with tag 2 and commit of x6 with its old tag 1 -> busy=1, tag=2, data updated.
5. Rename x8 with tag 1, save to slot 2, rename x8 with tag 4, commit tag 1, restore slot 2 -> x8 is not busy (the snapshot was cleared by the commit).
6. Flush with x3 and x9 busy while a commit to x9 is presented -> no register busy, x9 data written; a later restore of any slot -> no register busy.
